// File: rtl/iram_loader_if.sv
// ---------------------------------------------------------------------------
// iram_loader_if
//
// Purpose: bundles every signal between the program loader and its
// surroundings. These are the UART FIFOs, the micro's IRAM write port, the
// processor hold line, the start tick and the status flags. Clock and reset
// are not in the bundle; they stay plain ports on the loader.
//
// Modports:
//   master - the loader: samples start/rx_empty/r_data/tx_full and drives
//            everything else
//   slave  - the environment (UART FIFOs, micro, top level)
//
// Signals:
//   start     one-cycle tick that begins or restarts a load
//   rx_empty  UART RX FIFO empty
//   r_data    UART RX FIFO head byte
//   rd_uart   one-cycle pop of the RX FIFO
//   tx_full   UART TX FIFO full
//   wr_uart   one-cycle push to the TX FIFO
//   w_data    status byte pushed with wr_uart
//   iram_wa   IRAM write address
//   iram_wen  IRAM write enable, one cycle per word
//   iram_din  IRAM write data
//   cpu_hold  micro reset; 1 holds the processor
//   busy      load in progress
//   done      load finished (sticky)
//   error     load failed (sticky)
// ---------------------------------------------------------------------------
interface iram_loader_if #(
   parameter int WIDTH          = 16,
   parameter int IRAM_ADDR_BITS = 8
);
   logic                      start;
   logic                      rx_empty;
   logic [7:0]                r_data;
   logic                      rd_uart;
   logic                      tx_full;
   logic                      wr_uart;
   logic [7:0]                w_data;
   logic [IRAM_ADDR_BITS-1:0] iram_wa;
   logic                      iram_wen;
   logic [WIDTH-1:0]          iram_din;
   logic                      cpu_hold;
   logic                      busy;
   logic                      done;
   logic                      error;

   modport master (
      input  start, rx_empty, r_data, tx_full,
      output rd_uart, wr_uart, w_data, iram_wa, iram_wen, iram_din,
             cpu_hold, busy, done, error
   );

   modport slave (
      output start, rx_empty, r_data, tx_full,
      input  rd_uart, wr_uart, w_data, iram_wa, iram_wen, iram_din,
             cpu_hold, busy, done, error
   );
endinterface

// File: rtl/iram_loader.sv
// ---------------------------------------------------------------------------
// iram_loader
//
// Purpose: drains bytes from the UART RX FIFO and assembles them into
// instruction words, high byte first. Each word is written to consecutive
// IRAM addresses. The micro is held in reset while a load is in progress.
// When the load ends, a one-byte status is pushed into the UART TX FIFO:
// 'K' (0x4B) on success, 'E' (0x45) on failure.
//
// Ports:
//   clk    system clock, shared with the UART FIFOs and the micro
//   reset  synchronous, active-high; clears all state on the next edge
//   bus    iram_loader_if.master (FIFO handshakes, IRAM port, status flags)
//
// Parameters:
//   WIDTH           instruction word width (two bytes per word)
//   IRAM_ADDR_BITS  IRAM address width
//   WORDS           words per program image, 1..2**IRAM_ADDR_BITS
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a trailing checksum byte follows the image. This byte is
//   the modulo-256 sum of all data bytes. A mismatch sets error and keeps the
//   processor held. When undefined, no checksum byte is expected and error
//   never sets.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module iram_loader #(
   parameter int WIDTH          = 16,
   parameter int IRAM_ADDR_BITS = 8,
   parameter int WORDS          = 24
) (
   input  logic         clk,
   input  logic         reset,
   iram_loader_if.master bus
);

   localparam logic [IRAM_ADDR_BITS:0] LAST_WORD = (IRAM_ADDR_BITS+1)'(WORDS - 1);
   localparam logic [7:0] STATUS_OK  = 8'h4B;
   localparam logic [7:0] STATUS_ERR = 8'h45;

   typedef enum logic [2:0] {
      IDLE,
      RX_HI,
      RX_LO,
      WRITE,
`ifdef LOADER_CHECKSUM_EN
      CHK,
`endif
      ACK,
      DONE
   } state_t;

   state_t                    r_state;
   logic                      r_settle;
   logic [7:0]                r_hiByte;
   logic [7:0]                r_loByte;
   logic [7:0]                r_sum;
   logic [IRAM_ADDR_BITS:0]   r_wordCount;

   logic                      r_rdUart;
   logic                      r_wrUart;
   logic [7:0]                r_wData;
   logic [IRAM_ADDR_BITS-1:0] r_iramWa;
   logic                      r_iramWen;
   logic [WIDTH-1:0]          r_iramDin;
   logic                      r_cpuHold;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_error;

   // A byte can be taken only when the FIFO is non-empty and we are not in
   // the cycle right after a pop. In that cycle the FIFO head is still
   // updating.
   logic w_canFetch;
   assign w_canFetch = !bus.rx_empty && !r_settle;

   // Single registered FSM. start overrides every state, including the
   // pending-byte case, so a restart never loses the first byte of the new
   // image. Each receive state stays put through its own settle cycle and
   // only advances after it. This gives fetch+settle = 2 cycles per byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_settle    <= 1'b0;
         r_hiByte    <= 8'h00;
         r_loByte    <= 8'h00;
         r_sum       <= 8'h00;
         r_wordCount <= '0;
         r_rdUart    <= 1'b0;
         r_wrUart    <= 1'b0;
         r_wData     <= 8'h00;
         r_iramWa    <= '0;
         r_iramWen   <= 1'b0;
         r_iramDin   <= '0;
         r_cpuHold   <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else if (bus.start) begin
         r_state     <= RX_HI;
         r_settle    <= 1'b0;
         r_sum       <= 8'h00;
         r_wordCount <= '0;
         r_rdUart    <= 1'b0;
         r_wrUart    <= 1'b0;
         r_iramWa    <= '0;
         r_iramWen   <= 1'b0;
         r_cpuHold   <= 1'b1;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_rdUart  <= 1'b0;
         r_wrUart  <= 1'b0;
         r_iramWen <= 1'b0;
         r_settle  <= 1'b0;

         case (r_state)
            IDLE: begin
               // Stale bytes are thrown away so they cannot leak into the
               // next image.
               r_cpuHold <= 1'b1;
               if (w_canFetch) begin
                  r_rdUart <= 1'b1;
                  r_settle <= 1'b1;
               end
            end

            RX_HI: begin
               if (r_settle) begin
                  r_state <= RX_LO;
               end else if (!bus.rx_empty) begin
                  r_hiByte <= bus.r_data;
                  r_sum    <= r_sum + bus.r_data;
                  r_rdUart <= 1'b1;
                  r_settle <= 1'b1;
               end
            end

            RX_LO: begin
               if (r_settle) begin
                  r_state <= WRITE;
               end else if (!bus.rx_empty) begin
                  r_loByte <= bus.r_data;
                  r_sum    <= r_sum + bus.r_data;
                  r_rdUart <= 1'b1;
                  r_settle <= 1'b1;
               end
            end

            WRITE: begin
               // The address and data registers keep their values after the
               // enable drops. The address therefore never moves past the
               // last word written.
               r_iramWen   <= 1'b1;
               r_iramWa    <= r_wordCount[IRAM_ADDR_BITS-1:0];
               r_iramDin   <= WIDTH'({r_hiByte, r_loByte});
               r_wordCount <= r_wordCount + 1'b1;
               if (r_wordCount == LAST_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                  r_state <= CHK;
`else
                  r_state <= ACK;
`endif
               end else begin
                  r_state <= RX_HI;
               end
            end

`ifdef LOADER_CHECKSUM_EN
            CHK: begin
               // The checksum byte itself is not added to the sum.
               if (r_settle) begin
                  r_state <= ACK;
               end else if (!bus.rx_empty) begin
                  r_error  <= (bus.r_data != r_sum);
                  r_rdUart <= 1'b1;
                  r_settle <= 1'b1;
               end
            end
`endif

            ACK: begin
               if (!bus.tx_full) begin
                  r_wrUart <= 1'b1;
                  r_wData  <= r_error ? STATUS_ERR : STATUS_OK;
                  r_state  <= DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end
            end

            DONE: begin
               // The processor is released only on a clean load.
               r_cpuHold <= r_error;
               if (w_canFetch) begin
                  r_rdUart <= 1'b1;
                  r_settle <= 1'b1;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.rd_uart  = r_rdUart;
   assign bus.wr_uart  = r_wrUart;
   assign bus.w_data   = r_wData;
   assign bus.iram_wa  = r_iramWa;
   assign bus.iram_wen = r_iramWen;
   assign bus.iram_din = r_iramDin;
   assign bus.cpu_hold = r_cpuHold;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.error    = r_error;

endmodule
